// File: rtl/contatore_riconoscimenti_pkg.sv
// Shared state encoding and default sizing for the recognition counter.
package contatore_riconoscimenti_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'b00,
      REPORT   = 2'b01,
      WAIT_REL = 2'b10
   } state_t;

   localparam int unsigned W_DEF      = 8;
   localparam int unsigned THRESH_DEF = 4;

endpackage

// File: rtl/contatore_riconoscimenti_rilevatore_fronte.sv
// Rising-edge detector: one-cycle ev pulse for each 0->1 transition of z_i.
module rilevatore_fronte (
   input  logic clock,
   input  logic reset,
   input  logic z_i,
   output logic ev_o
);

   logic z_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         z_q <= 1'b0;
      end else begin
         z_q <= z_i;
      end
   end

   assign ev_o = z_i & ~z_q;

endmodule

// File: rtl/contatore_riconoscimenti.sv
// Counts recognitions and publishes a snapshot every THRESH events over a 4-phase valid/ack link.
// CONTATORE_RICONOSCIMENTI_SAT_EN makes the running count saturate instead of wrapping.
module contatore_riconoscimenti
   import contatore_riconoscimenti_pkg::*;
#(
   parameter int unsigned W      = W_DEF,
   parameter int unsigned THRESH = THRESH_DEF
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         z,
   input  logic         ack,
   output logic [W-1:0] count,
   output logic         valid,
   output logic         lost
);

   localparam int unsigned BW = $clog2(THRESH + 1);

   state_t        state_q, state_d;
   logic [W-1:0]  cnt_q, cnt_d, cnt_nxt;
   logic [BW-1:0] batch_q, batch_d;
   logic [W-1:0]  count_q, count_d;
   logic [W-1:0]  pend_snap_q, pend_snap_d;
   logic          valid_q, valid_d;
   logic          pending_q, pending_d;
   logic          lost_q, lost_d;
   logic          ev, done;

   rilevatore_fronte u_fronte (
      .clock (clock),
      .reset (reset),
      .z_i   (z),
      .ev_o  (ev)
   );

`ifdef CONTATORE_RICONOSCIMENTI_SAT_EN
   assign cnt_nxt = (&cnt_q) ? cnt_q : cnt_q + W'(1);
`else
   assign cnt_nxt = cnt_q + W'(1);
`endif

   assign done = ev && (batch_q == BW'(THRESH - 1));

   always_comb begin
      cnt_d       = cnt_q;
      batch_d     = batch_q;
      state_d     = state_q;
      count_d     = count_q;
      valid_d     = valid_q;
      pending_d   = pending_q;
      pend_snap_d = pend_snap_q;
      lost_d      = lost_q;

      if (ev) begin
         cnt_d   = cnt_nxt;
         batch_d = done ? '0 : batch_q + BW'(1);
      end

      unique case (state_q)
         IDLE: begin
            if (done) begin
               count_d = cnt_nxt;
               valid_d = 1'b1;
               state_d = REPORT;
            end
         end
         WAIT_REL: begin
            if (!ack) begin
               if (pending_q) begin
                  // Drain the slot; a batch finishing on this edge refills it.
                  count_d     = pend_snap_q;
                  valid_d     = 1'b1;
                  state_d     = REPORT;
                  pending_d   = done;
                  pend_snap_d = done ? cnt_nxt : pend_snap_q;
               end else if (done) begin
                  count_d = cnt_nxt;
                  valid_d = 1'b1;
                  state_d = REPORT;
               end else begin
                  state_d = IDLE;
               end
            end else if (done) begin
               if (pending_q) begin
                  lost_d = 1'b1;
               end else begin
                  pending_d   = 1'b1;
                  pend_snap_d = cnt_nxt;
               end
            end
         end
         default: begin
            if (ack) begin
               valid_d = 1'b0;
               state_d = WAIT_REL;
            end
            if (done) begin
               if (pending_q) begin
                  lost_d = 1'b1;
               end else begin
                  pending_d   = 1'b1;
                  pend_snap_d = cnt_nxt;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         batch_q     <= '0;
         count_q     <= '0;
         valid_q     <= 1'b0;
         pending_q   <= 1'b0;
         pend_snap_q <= '0;
         lost_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         batch_q     <= batch_d;
         count_q     <= count_d;
         valid_q     <= valid_d;
         pending_q   <= pending_d;
         pend_snap_q <= pend_snap_d;
         lost_q      <= lost_d;
      end
   end

   assign count = count_q;
   assign valid = valid_q;
   assign lost  = lost_q;

endmodule

// File: tb/tb_contatore_riconoscimenti.sv
// Scoreboard bench: stimulus pushes expected snapshots, monitors pop them on each valid rise.
module tb_contatore_riconoscimenti;

   typedef struct {
      int cnt;
      int lst;
   } exp_t;

   logic       clock = 1'b0;
   logic       rst_a, z_a, ack_a, valid_a, lost_a;
   logic [7:0] count_a;
   logic       rst_b, z_b, ack_b, valid_b, lost_b;
   logic [2:0] count_b;

   exp_t qa[$];
   int   qb[$];
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clock = ~clock;

   contatore_riconoscimenti #(.W(8), .THRESH(4)) dut_a (
      .clock (clock), .reset (rst_a), .z (z_a), .ack (ack_a),
      .count (count_a), .valid (valid_a), .lost (lost_a)
   );

   contatore_riconoscimenti #(.W(3), .THRESH(1)) dut_b (
      .clock (clock), .reset (rst_b), .z (z_b), .ack (ack_b),
      .count (count_b), .valid (valid_b), .lost (lost_b)
   );

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      rst_a = 1'b1; z_a = 1'b0; ack_a = 1'b0;
      rst_b = 1'b1; z_b = 1'b0; ack_b = 1'b0;
      tick();
      tick();
      rst_a = 1'b0;
      rst_b = 1'b0;
   endtask

   task automatic pulse_a();
      z_a = 1'b1;
      tick();
      z_a = 1'b0;
      tick();
      tick();
   endtask

   task automatic pulses_a(input int n);
      for (int i = 0; i < n; i++) pulse_a();
   endtask

   // Monitor for the W=8 / THRESH=4 instance
   initial begin
      logic prev;
      exp_t e;
      prev = 1'b0;
      forever begin
         @(negedge clock);
         if (valid_a && !prev) begin
            if (qa.size() == 0) begin
               chk("a_unexpected_report", int'(count_a), -1);
            end else begin
               e = qa.pop_front();
               chk("a_report_count", int'(count_a), e.cnt);
               chk("a_report_lost", int'(lost_a), e.lst);
            end
         end
         prev = valid_a;
      end
   end

   // Monitor for the W=3 / THRESH=1 instance
   initial begin
      logic prev;
      int   e;
      prev = 1'b0;
      forever begin
         @(negedge clock);
         if (valid_b && !prev) begin
            if (qb.size() == 0) begin
               chk("b_unexpected_report", int'(count_b), -1);
            end else begin
               e = qb.pop_front();
               chk("b_report_count", int'(count_b), e);
               chk("b_report_lost", int'(lost_b), 0);
            end
         end
         prev = valid_b;
      end
   end

   initial begin
      int ev_exp;
      exp_t e;

      do_reset();
      chk("rst_count", int'(count_a), 0);
      chk("rst_valid", int'(valid_a), 0);
      chk("rst_lost", int'(lost_a), 0);
      chk("rst_b_valid", int'(valid_b), 0);

      // Narrow counter with one report per event: wrap (or saturate) past 7
      for (int i = 1; i <= 9; i++) begin
`ifdef CONTATORE_RICONOSCIMENTI_SAT_EN
         ev_exp = (i > 7) ? 7 : i;
`else
         ev_exp = i % 8;
`endif
         qb.push_back(ev_exp);
         z_b = 1'b1;
         tick();
         chk("b_valid_after_event", int'(valid_b), 1);
         z_b = 1'b0;
         ack_b = 1'b1;
         tick();
         chk("b_valid_after_ack", int'(valid_b), 0);
         ack_b = 1'b0;
         tick();
      end

      // Four short pulses, no ack
      do_reset();
      e.cnt = 4; e.lst = 0; qa.push_back(e);
      pulses_a(3);
      chk("t1_valid_before_4th", int'(valid_a), 0);
      z_a = 1'b1;
      tick();
      chk("t1_valid_latency", int'(valid_a), 1);
      z_a = 1'b0;
      repeat (5) tick();
      chk("t1_valid_held", int'(valid_a), 1);
      chk("t1_count_held", int'(count_a), 4);
      chk("t1_lost", int'(lost_a), 0);

      // Held-high z counts once per rise
      do_reset();
      e.cnt = 4; e.lst = 0; qa.push_back(e);
      for (int k = 0; k < 4; k++) begin
         z_a = 1'b1;
         repeat (10) tick();
         z_a = 1'b0;
         repeat (3) tick();
         if (k < 3) chk("t2_no_early_report", int'(valid_a), 0);
      end
      chk("t2_valid", int'(valid_a), 1);
      chk("t2_count", int'(count_a), 4);

      // Delayed ack: second batch waits in pending, published when ack releases
      do_reset();
      e.cnt = 4; e.lst = 0; qa.push_back(e);
      pulses_a(4);
      e.cnt = 8; e.lst = 0; qa.push_back(e);
      pulses_a(4);
      repeat (8) tick();
      chk("t3_count_frozen", int'(count_a), 4);
      ack_a = 1'b1;
      tick();
      chk("t3_valid_fall", int'(valid_a), 0);
      tick();
      chk("t3_wait_rel_hold", int'(valid_a), 0);
      ack_a = 1'b0;
      tick();
      chk("t3_valid_rerise", int'(valid_a), 1);
      chk("t3_count_pending", int'(count_a), 8);
      ack_a = 1'b1;
      tick();
      ack_a = 1'b0;
      tick();
      chk("t3_idle", int'(valid_a), 0);

      // Never-acking consumer: third batch overflows
      do_reset();
      e.cnt = 4; e.lst = 0; qa.push_back(e);
      pulses_a(11);
      chk("t4_lost_before_12th", int'(lost_a), 0);
      z_a = 1'b1;
      tick();
      chk("t4_lost_at_12th", int'(lost_a), 1);
      chk("t4_count_held", int'(count_a), 4);
      z_a = 1'b0;
      tick();
      tick();
      e.cnt = 8; e.lst = 1; qa.push_back(e);
      ack_a = 1'b1;
      tick();
      ack_a = 1'b0;
      tick();
      chk("t4_pending_pub", int'(count_a), 8);
      chk("t4_lost_sticky", int'(lost_a), 1);
      ack_a = 1'b1;
      tick();
      ack_a = 1'b0;
      tick();
      chk("t4_idle", int'(valid_a), 0);

      // Reset while reporting with a full pending slot and lost set
      e.cnt = 16; e.lst = 1; qa.push_back(e);
      pulses_a(8);
      chk("t6_pre_valid", int'(valid_a), 1);
      chk("t6_pre_count", int'(count_a), 16);
      rst_a = 1'b1;
      tick();
      chk("t6_rst_valid", int'(valid_a), 0);
      chk("t6_rst_count", int'(count_a), 0);
      chk("t6_rst_lost", int'(lost_a), 0);
      rst_a = 1'b0;
      e.cnt = 4; e.lst = 0; qa.push_back(e);
      pulses_a(4);
      chk("t6_post_count", int'(count_a), 4);

      repeat (4) tick();
      chk("a_reports_outstanding", qa.size(), 0);
      chk("b_reports_outstanding", qb.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
